// File: rtl/upc_pkg.sv
// upc_pkg: shared types and defaults for the micro-program sequencer.
//   upc_op_e  - 3-bit sequencer opcode
//   *_DEF     - default parameter values (micro-PC width, stack depth, loop counter width)
package upc_pkg;

   typedef enum logic [2:0] {
      OP_INCR  = 3'd0,
      OP_JUMP  = 3'd1,
      OP_JCOND = 3'd2,
      OP_CALL  = 3'd3,
      OP_RET   = 3'd4,
      OP_LDCNT = 3'd5,
      OP_LOOP  = 3'd6,
      OP_HOLD  = 3'd7
   } upc_op_e;

   localparam int AW_DEF    = 5;
   localparam int DEPTH_DEF = 4;
   localparam int CW_DEF    = 4;

   // Stack pointer must count 0..DEPTH inclusive.
   function automatic int sp_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/upc_seq_if.sv
// upc_seq_if: control/status bundle of the micro-program sequencer.
//   en, op, cond, target            - command from the control ROM side
//   upc                             - registered micro-PC
//   stack_full, stack_empty         - return-stack status
//   loop_busy, err                  - loop counter nonzero, sticky stack error
// master: drives the command (ROM/controller side); slave: the sequencer.
interface upc_seq_if
   import upc_pkg::*;
#(
   parameter int AW = AW_DEF
);
   logic          en;
   upc_op_e       op;
   logic          cond;
   logic [AW-1:0] target;
   logic [AW-1:0] upc;
   logic          stack_full;
   logic          stack_empty;
   logic          loop_busy;
   logic          err;

   modport master (
      output en, op, cond, target,
      input  upc, stack_full, stack_empty, loop_busy, err
   );

   modport slave (
      input  en, op, cond, target,
      output upc, stack_full, stack_empty, loop_busy, err
   );
endinterface

// File: rtl/upc_stack.sv
// upc_stack: return-address LIFO.
//   clk, reset  - clock, async active-high reset (clears pointer only)
//   push, pop   - push din / pop top; push-when-full and pop-when-empty ignored
//   din, dout   - data in, current top of stack (undefined when empty)
//   full, empty - occupancy flags, combinational from the pointer
module upc_stack
   import upc_pkg::*;
#(
   parameter int W     = AW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int SPW = sp_width(DEPTH);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]   mem [DEPTH];
   logic [SPW-1:0] sp;
   logic [SPW-1:0] top;

   assign full  = (sp == SPW'(DEPTH));
   assign empty = (sp == '0);
   assign top   = sp - 1'b1;
   // When empty the index wraps to a stale slot; callers never use it then.
   assign dout  = mem[IW'(top)];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sp <= '0;
      else if (push && !full)
         sp <= sp + 1'b1;
      else if (pop && !empty)
         sp <= sp - 1'b1;
   end

   // Contents are not reset; only the pointer defines validity.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[IW'(sp)] <= din;
   end
endmodule

// File: rtl/upc_seq.sv
// upc_seq: micro-program sequencer producing the control-ROM address.
//   clk, reset - clock, async active-high reset
//   bus        - upc_seq_if.slave: en/op/cond/target in; upc, stack_full,
//                stack_empty, loop_busy, err out
// Holds the micro-PC register, the single loop counter and the sticky error
// flag; return addresses live in upc_stack.
module upc_seq
   import upc_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic      clk,
   input  logic      reset,
   upc_seq_if.slave  bus
);
   logic [AW-1:0] upc;
   logic [AW-1:0] inc;
   logic [CW-1:0] cnt;
   logic          err;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [AW-1:0] ret_addr;

   assign inc  = upc + 1'b1;   // wraps silently at 2**AW-1
   assign push = bus.en && (bus.op == OP_CALL) && !full;
   assign pop  = bus.en && (bus.op == OP_RET)  && !empty;

   upc_stack #(.W(AW), .DEPTH(DEPTH)) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (inc),
      .dout  (ret_addr),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         upc <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else if (bus.en) begin
         case (bus.op)
            OP_INCR:  upc <= inc;
            OP_JUMP:  upc <= bus.target;
            OP_JCOND: upc <= bus.cond ? bus.target : inc;
            OP_CALL: begin
               if (!full) upc <= bus.target;
               else       err <= 1'b1;
            end
            OP_RET: begin
               if (!empty) upc <= ret_addr;
               else        err <= 1'b1;
            end
            OP_LDCNT: begin
               cnt <= bus.target[CW-1:0];
               upc <= inc;
            end
            OP_LOOP: begin
               // Count N runs the body N+1 times: branch while nonzero.
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
                  upc <= bus.target;
               end else begin
                  upc <= inc;
               end
            end
            default: ;  // OP_HOLD
         endcase
      end
   end

   assign bus.upc         = upc;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.loop_busy   = (cnt != '0);
   assign bus.err         = err;
endmodule
